sgr_sequencer: RTL and testbench

SGR_SEQUENCER -- requirements
Module: sgr_sequencer

---
 rtl/sgr_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sgr_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgr_sequencer.sv
// sgr_sequencer -- collects the decimal parameter list of an SGR escape
// sequence (the characters after CSI up to 'm') and replays it to the
// graphics state block as a train of single-cycle command strobes.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   seq_start          CSI seen: start a new parameter list
//   in_valid, in_char  character stream following the CSI
//   in_ready           character accepted when in_valid && in_ready
//   commandReady       one-cycle command strobe
//   commandType, Pns   command and its parameter (held between strobes)
//   busy               high whenever the sequencer is not IDLE
//   seq_abort          one-cycle pulse when a list is discarded
//   overflow           sticky: a parameter was dropped (cleared by seq_start)

package sgr_pkg;
    typedef enum logic [1:0] {
        SGR0    = 2'd0,
        INIT_PN = 2'd1,
        EMIT_PN = 2'd2,
        SGR     = 2'd3
    } CommandsType;
endpackage

module sgr_sequencer
    import sgr_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PN_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seq_start,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        commandReady,
    output CommandsType commandType,
    output logic [7:0]  Pns,
    output logic        busy,
    output logic        seq_abort,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, GAP} state_t;

    state_t         state;
    logic [7:0]     acc;
    logic [CW-1:0]  count;
    logic [CW-1:0]  idx;
    logic [7:0]     pbuf [DEPTH];
    logic           any_char;    // a character was accepted since seq_start
    logic           empty_list;  // bare 'm': issue a lone SGR0
    logic           last_sent;   // the closing SGR has gone out

    logic           accept;
    logic           is_digit;
    logic [11:0]    acc_mul;
    logic [7:0]     acc_sat;
    logic           push_en;
    logic           full;

    // seq_start takes priority over any character presented in the same
    // cycle, so the character is refused rather than silently dropped.
    assign in_ready = (state == IDLE || state == COLLECT) && !seq_start;
    assign busy     = (state != IDLE);
    assign accept   = (state == COLLECT) && in_valid && in_ready;

    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign acc_mul  = 12'(acc) * 12'd10 + 12'(in_char[3:0]);
    assign acc_sat  = (acc_mul > 12'(PN_MAX)) ? 8'(PN_MAX) : acc_mul[7:0];

    // ';' always closes a field (empty field -> 0); 'm' closes the last
    // field only when the list is not bare.
    assign push_en  = accept && ((in_char == 8'h3b) || (in_char == 8'h6d && any_char));
    assign full     = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            idx          <= '0;
            any_char     <= 1'b0;
            empty_list   <= 1'b0;
            last_sent    <= 1'b0;
            commandReady <= 1'b0;
            commandType  <= SGR0;
            Pns          <= '0;
            seq_abort    <= 1'b0;
            overflow     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) pbuf[i] <= '0;
        end else begin
            commandReady <= 1'b0;
            seq_abort    <= 1'b0;

            case (state)
                IDLE, COLLECT: begin
                    if (seq_start) begin
                        // Also the restart path from COLLECT: no abort pulse.
                        state      <= COLLECT;
                        acc        <= '0;
                        count      <= '0;
                        any_char   <= 1'b0;
                        empty_list <= 1'b0;
                        overflow   <= 1'b0;
                    end else if (accept) begin
                        if (is_digit) begin
                            acc      <= acc_sat;
                            any_char <= 1'b1;
                        end else if (in_char == 8'h3b) begin
                            acc      <= '0;
                            any_char <= 1'b1;
                        end else if (in_char == 8'h6d) begin
                            // First strobe leaves on this edge; its payload is
                            // constant so it need not wait for the final push.
                            state        <= ISSUE;
                            idx          <= '0;
                            last_sent    <= 1'b0;
                            commandReady <= 1'b1;
                            Pns          <= '0;
                            if (any_char) begin
                                commandType <= INIT_PN;
                            end else begin
                                commandType <= SGR0;
                                empty_list  <= 1'b1;
                            end
                        end else begin
                            state     <= IDLE;
                            seq_abort <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                        end
                    end
                end

                ISSUE: state <= GAP;

                GAP: begin
                    if (empty_list || last_sent) begin
                        state <= IDLE;
                    end else begin
                        state        <= ISSUE;
                        commandReady <= 1'b1;
                        Pns          <= pbuf[idx[AW-1:0]];
                        idx          <= idx + CW'(1);
                        if (idx == count - CW'(1)) begin
                            commandType <= SGR;
                            last_sent   <= 1'b1;
                        end else begin
                            commandType <= EMIT_PN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // A full buffer drops the value but keeps what it holds.
            if (push_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    pbuf[count[AW-1:0]] <= acc;
                    count               <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sgr_sequencer.sv
module tb_sgr_sequencer;
    import sgr_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PN_MAX = 255;

    logic        clk;
    logic        rst_n;
    logic        seq_start;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        commandReady;
    CommandsType commandType;
    logic [7:0]  Pns;
    logic        busy;
    logic        seq_abort;
    logic        overflow;

    sgr_sequencer #(.DEPTH(DEPTH), .PN_MAX(PN_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seq_start    (seq_start),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_ready     (in_ready),
        .commandReady (commandReady),
        .commandType  (commandType),
        .Pns          (Pns),
        .busy         (busy),
        .seq_abort    (seq_abort),
        .overflow     (overflow)
    );

    typedef struct {
        CommandsType t;
        logic [7:0]  p;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    logic prev_cr = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every strobe must match the next expected command,
    // including the cycle it was predicted for.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && commandReady) begin
            vectors++;
            if (prev_cr) begin
                errors++;
                $display("FAIL gap: strobe in consecutive cycles at cycle %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %s/%0d at cycle %0d, required none",
                         commandType.name(), Pns, cyc);
            end else begin
                e = exp_q.pop_front();
                if (commandType !== e.t || Pns !== e.p || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL command: got %s/%0d at cycle %0d, required %s/%0d at cycle %0d",
                             commandType.name(), Pns, cyc, e.t.name(), e.p, e.cyc);
                end
            end
        end
        prev_cr = rst_n && commandReady;
    end

    // Reference parse of the character string into the expected command train.
    // limit < 0 queues every command, otherwise only the first 'limit'.
    task automatic push_expected(input string s, input int base, input int limit);
        int   vals[$];
        int   acc = 0;
        bit   any = 0;
        byte  c;
        exp_t e;
        exp_t all[$];
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c >= "0" && c <= "9") begin
                any = 1;
                acc = acc * 10 + (c - "0");
                if (acc > PN_MAX) acc = PN_MAX;
            end else if (c == ";") begin
                any = 1;
                if (vals.size() < DEPTH) vals.push_back(acc);
                acc = 0;
            end else if (c == "m") begin
                if (any && vals.size() < DEPTH) vals.push_back(acc);
            end
        end
        if (!any) begin
            e.t = SGR0; e.p = 8'd0; e.cyc = base; all.push_back(e);
        end else begin
            e.t = INIT_PN; e.p = 8'd0; e.cyc = base; all.push_back(e);
            for (int i = 0; i < vals.size(); i++) begin
                e.t   = (i == vals.size() - 1) ? SGR : EMIT_PN;
                e.p   = 8'(vals[i]);
                e.cyc = base + 2 * (i + 1);
                all.push_back(e);
            end
        end
        for (int i = 0; i < all.size(); i++)
            if (limit < 0 || i < limit) exp_q.push_back(all[i]);
    endtask

    // Drives an optional seq_start then the characters back to back.
    // Returns at the negedge following the last accepted character.
    task automatic send(input string s, input int limit, input bit start);
        byte c;
        if (start) begin
            @(negedge clk);
            seq_start = 1'b1;
            in_valid  = 1'b0;
            @(negedge clk);
            seq_start = 1'b0;
        end
        for (int i = 0; i < s.len(); i++) begin
            c        = s[i];
            in_valid = 1'b1;
            in_char  = c;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_collect: got %b for char '%c', required 1", in_ready, c);
            end
            if (c == "m") push_expected(s, cyc + 1, limit);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        #1;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d commands outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called in the cycle of the final strobe: one GAP cycle, then IDLE.
    task automatic check_tail(input string tag);
        @(negedge clk); #1;
        vectors++;
        if (commandReady !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap: got cr=%b busy=%b rdy=%b, required 0 1 0",
                     tag, commandReady, busy, in_ready);
        end
        @(negedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b rdy=%b, required 0 1", tag, busy, in_ready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (in_ready !== 1'b1 || commandReady !== 1'b0 || commandType !== SGR0 ||
            Pns !== 8'd0 || busy !== 1'b0 || seq_abort !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b cr=%b type=%s pns=%0d busy=%b abort=%b ovf=%b, required 1 0 SGR0 0 0 0 0",
                     tag, in_ready, commandReady, commandType.name(), Pns, busy, seq_abort, overflow);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seq_start = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        #1;
        check_reset_values("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_reset_values("after_release");
    endtask

    task automatic test_bare_m();
        send("m", -1, 1'b1);
        wait_done();
        check_tail("bare_m");
    endtask

    task automatic test_basic();
        send("1;31m", -1, 1'b1);
        wait_done();
        check_tail("basic");
    endtask

    task automatic test_saturate();
        send("38;2;300;;7m", -1, 1'b1);
        wait_done();
        check_tail("saturate");
        send("99999;0m", -1, 1'b1);
        wait_done();
        check_tail("saturate_long");
    endtask

    task automatic test_overflow();
        string s = "";
        for (int i = 1; i <= 17; i++) s = {s, $sformatf(i == 17 ? "%0dm" : "%0d;", i)};
        send(s, -1, 1'b1);
        wait_done();
        check_tail("overflow");
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow);
        end
        @(negedge clk); seq_start = 1'b1;
        @(negedge clk); seq_start = 1'b0;
        #1;
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_abort();
        send("3x", -1, 1'b1);
        #1;
        vectors++;
        if (seq_abort !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse: got abort=%b busy=%b rdy=%b, required 1 0 1",
                     seq_abort, busy, in_ready);
        end
        @(negedge clk); #1;
        vectors++;
        if (seq_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_width: got %b, required 0", seq_abort);
        end
        send("0m", -1, 1'b1);
        wait_done();
        check_tail("after_abort");
    endtask

    task automatic test_restart();
        send("12;", -1, 1'b1);
        send("4m", -1, 1'b1);
        #1;
        vectors++;
        if (seq_abort !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_abort: got %b, required 0", seq_abort);
        end
        wait_done();
        check_tail("restart");
    endtask

    task automatic test_start_collision();
        @(negedge clk);
        seq_start = 1'b1; in_valid = 1'b1; in_char = "m";
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready: got %b, required 0", in_ready);
        end
        @(negedge clk);
        seq_start = 1'b0; in_valid = 1'b0;
        send("7m", -1, 1'b0);
        wait_done();
        check_tail("collision");
    endtask

    task automatic test_start_during_issue();
        send("1;2;3m", -1, 1'b1);
        #1;
        seq_start = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_ready: got %b, required 0", in_ready);
        end
        @(negedge clk);
        seq_start = 1'b0;
        wait_done();
        check_tail("start_in_issue");
    endtask

    task automatic test_reset_mid_issue();
        send("1;2;3m", 2, 1'b1);
        wait_done();
        // Now in the EMIT_PN strobe cycle; pull reset before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy: got %b, required 0", busy);
        end
        send("5m", -1, 1'b1);
        wait_done();
        check_tail("after_reset");
    endtask

    task automatic test_back_to_back();
        send("4;5m", -1, 1'b1);
        wait_done();
        check_tail("b2b_a");
        send("9m", -1, 1'b1);
        wait_done();
        check_tail("b2b_b");
    endtask

    initial begin
        test_reset();
        test_bare_m();
        test_basic();
        test_saturate();
        test_overflow();
        test_abort();
        test_restart();
        test_start_collision();
        test_start_during_issue();
        test_reset_mid_issue();
        test_back_to_back();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d queued commands, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
